// File: rtl/unary_pkg.sv
// Shared helpers for the RNG-based unary kernels: LFSR8 taps/step, seed fix-up
// and shuffle-index width.
package unary_pkg;

   // x^8+x^6+x^5+x^4+1 as a Fibonacci left-shift feedback mask (bits 7,5,4,3)
   localparam logic [7:0] LFSR8_TAPS = 8'hB8;

   // Widest shuffle index over the legal depths (2..16)
   typedef logic [3:0] idx_w_t;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR8_TAPS)};
   endfunction

   // All-zero is the LFSR lock-up state, so it is mapped to 8'h01
   function automatic logic [7:0] lfsr8_seed(input logic [7:0] s);
      return (s == 8'h00) ? 8'h01 : s;
   endfunction

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit maximal-length LFSR, period 255, async active-low reset to seed.
module lfsr8
   import unary_pkg::*;
#(
   parameter logic [7:0] SEED = 8'h2D
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] state
);

   localparam logic [7:0] SEED_EFF = lfsr8_seed(SEED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEED_EFF;
      else        state <= lfsr8_next(state);
   end

endmodule

// File: rtl/bisquare_shuffle_u.sv
// Stochastic squarer: multiplies the input stream by an LFSR-shuffled, delayed
// copy of itself (XNOR for bipolar, AND for unipolar).
module bisquare_shuffle_u
   import unary_pkg::*;
#(
   parameter int         DEPTH   = 4,
   parameter bit         BIPOLAR = 1'b1,
   parameter logic [7:0] SEED    = 8'h2D
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out
);

   localparam int IW = idx_w(DEPTH);

   logic [DEPTH-1:0] shuf_q;
   logic [7:0]       lf;
   logic [IW-1:0]    idx;
   logic             d;
   logic             unused_lf;

   lfsr8 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .state (lf)
   );

   assign idx       = lf[IW-1:0];
   assign unused_lf = ^lf[7:IW];
   assign d         = shuf_q[idx];

   // d always comes from an earlier cycle, so in is never squared against itself
   generate
      if (BIPOLAR) begin : g_bip
         assign out = ~(in ^ d);
      end else begin : g_uni
         assign out = in & d;
      end
   endgenerate

   // Alternating reset pattern starts the buffer at bipolar zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) shuf_q[i] <= i[0];
      end else begin
         shuf_q[idx] <= in;
      end
   end

endmodule

// File: tb/tb_bisquare_shuffle_u.sv
// Scoreboard bench for bisquare_shuffle_u: directed vectors, saturation, density,
// LFSR period/seed and async mid-stream reset.
module tb_bisquare_shuffle_u;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic in_a  = 1'b0;
   logic in_b  = 1'b0;
   logic in_c  = 1'b0;
   logic out_a, out_z, out_b, out_c;

   always #5 clk = ~clk;

   bisquare_shuffle_u #(.DEPTH(4), .BIPOLAR(1'b1), .SEED(8'h01)) dut (
      .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a));
   bisquare_shuffle_u #(.DEPTH(4), .BIPOLAR(1'b1), .SEED(8'h00)) dut_z (
      .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_z));
   bisquare_shuffle_u #(.DEPTH(8), .BIPOLAR(1'b1)) dut_b8 (
      .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b));
   bisquare_shuffle_u #(.DEPTH(4), .BIPOLAR(1'b0)) dut_u (
      .clk(clk), .rst_n(rst_n), .in(in_c), .out(out_c));

   int   errors = 0;
   int   checks = 0;
   logic exp_q[$];

   // Reference state for the DEPTH=4, SEED=01 bipolar instance
   logic [3:0] m_buf = 4'b1010;
   logic [7:0] m_lf  = 8'h01;

   int ones_b = 0;
   int ones_c = 0;
   bit acc_on = 1'b0;
   int pcnt   = 0;
   int pval   = 0;
   bit pfound = 1'b0;

   // Hand-derived vector from reset, SEED=01, DEPTH=4 (bit i = cycle i)
   logic [7:0] hv_in  = 8'h2B;
   logic [7:0] hv_out = 8'h25;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic chk_rng(input string name, input int v, input int lo, input int hi);
      checks++;
      if (v < lo || v > hi) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
      end
   endtask

   function automatic logic model_out(input logic a);
      return ~(a ^ m_buf[m_lf[1:0]]);
   endfunction

   // Called just after a rising edge; hand < 0 means take the reference model value
   task automatic step(input logic a, input logic b, input logic c, input int hand);
      in_a = a; in_b = b; in_c = c;
      exp_q.push_back((hand < 0) ? model_out(a) : hand[0]);
      #1;
      if (acc_on) begin
         ones_b += int'(out_b);
         ones_c += int'(out_c);
      end
      @(posedge clk);
      m_buf[m_lf[1:0]] = a;
      m_lf = {m_lf[6:0], ^(m_lf & 8'hB8)};
      #1;
   endtask

   task automatic rand_step();
      logic a, b, c;
      a = 1'($urandom_range(1));
      b = ($urandom_range(3) != 0);
      c = 1'($urandom_range(1));
      step(a, b, c, -1);
   endtask

   initial begin : mon
      logic e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out", out_a, e);
            chk("out_seed0", out_z, e);
         end
      end
   end

   // Edges since reset until the SEED=2D LFSR first returns to its seed
   initial begin : per
      forever begin
         @(negedge clk);
         if (rst_n && !pfound) begin
            if (pcnt != 0 && dut_b8.lf == 8'h2D) begin
               pfound = 1'b1;
               pval   = pcnt;
            end
            pcnt++;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: run did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : main
      #6 rst_n = 1'b1;
      #1;
      chk("rst_lf", dut.lf, 8'h01);
      chk("rst_lf_seed0", dut_z.lf, 8'h01);
      chk("rst_buf", dut.shuf_q, 4'b1010);
      chk("rst_lf_2d", dut_b8.lf, 8'h2D);
      in_a = 1'b0; #1;
      chk("rst_out_in0", out_a, 0);
      in_a = 1'b1; #1;
      chk("rst_out_in1", out_a, 1);

      for (int i = 0; i < 8; i++) step(hv_in[i], 1'b0, 1'b0, int'(hv_out[i]));

      for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, (i >= 32) ? 1 : -1);
      for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b0, (i >= 32) ? 1 : -1);

      for (int i = 0; i < 32; i++) rand_step();
      acc_on = 1'b1;
      for (int i = 0; i < 4096; i++) rand_step();
      acc_on = 1'b0;
      chk_rng("bipolar_density_x4096", ones_b, 2438, 2682);
      chk_rng("unipolar_density_x4096", ones_c, 902, 1146);
      chk("lfsr_period", pval, 255);

      for (int i = 0; i < 100; i++) rand_step();
      in_a  = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_lf", dut.lf, 8'h01);
      chk("midrst_buf", dut.shuf_q, 4'b1010);
      chk("midrst_lf_seed0", dut_z.lf, 8'h01);
      chk("midrst_out_in0", out_a, 0);
      in_a = 1'b1; #1;
      chk("midrst_out_in1", out_a, 1);
      rst_n = 1'b1;
      m_buf = 4'b1010;
      m_lf  = 8'h01;
      for (int i = 0; i < 8; i++) step(hv_in[i], 1'b0, 1'b0, int'(hv_out[i]));

      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bisquare_shuffle_u.md
# bisquare_shuffle_u

Bipolar/unipolar stochastic squarer for the unary kernel library. It is the inverse companion of the JK-flip-flop square-root kernel: it consumes one unary bitstream and produces a stream whose value is the square of the input. The input is multiplied by a decorrelated copy of itself, taken from a small LFSR-indexed shuffle buffer. It sits in the same `hw/kernel` tree as the other one-bit-in/one-bit-out kernels and uses the same port style.

## Interface
- `DEPTH`, default 4: shuffle-buffer size. Legal values are 2, 4, 8 or 16 (power of two).
- `BIPOLAR`, default 1: 1 = bipolar coding (XNOR multiply); 0 = unipolar coding (AND multiply).
- `SEED`, default 8'h2D: LFSR reset state. 8'h00 is illegal and is substituted with 8'h01 at elaboration.
- `clk  input  1`: clock. Rising-edge active.
- `rst_n  input  1`: reset. Asynchronous, active-low.
- `in  input  1`: input unary bitstream, one bit per cycle.
- `out  output  1`: squared bitstream, one bit per cycle.

## Operation
- State:
  - `buf[DEPTH]`, 1-bit entries.
  - 8-bit LFSR `lf`.
- Index: `idx = lf[log2(DEPTH)-1:0]`. This is a combinational read of the current LFSR state.
- Delayed operand: `d = buf[idx]`.
- Output, combinational from `in` and registered state:
  - `BIPOLAR=1`: `out = ~(in ^ d)`.
  - `BIPOLAR=0`: `out = in & d`.
- Every rising edge with `rst_n`=1:
  - `buf[idx] <= in`: the incoming bit replaces the bit just consumed.
  - The LFSR advances: `lf <= {lf[6:0], lf[7]^lf[5]^lf[4]^lf[3]}`, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - All other buffer entries hold.
- Reset values:
  - `buf[i] = i[0]`, alternating 0,1. This gives a bipolar-zero mean at start.
  - `lf = SEED`.
- Reset mid-stream: on `rst_n` falling, buffer and LFSR take their reset values immediately, without waiting for a clock edge. `out` then reflects the reset buffer combined with the current `in`.
- Self-write is intended. The same cycle's `in` is never multiplied with itself, because `d` is always a bit from an earlier cycle.
- No enable and no stall: the block consumes one bit per clock, unconditionally.

## Timing
- `out` has zero-cycle latency from `in` (combinational path through the XNOR/AND).
- `out` changes on the clock edge only through `buf`/`lf` updates, and otherwise only with `in`.
- Minimum decorrelation delay is 1 cycle. The expected delay of a bit in the buffer is DEPTH cycles.
- After reset, the first DEPTH–~2·DEPTH output bits are biased by the initial buffer pattern. Accuracy checks exclude a warm-up of 4·DEPTH cycles.
- The LFSR sequence repeats every 255 cycles. There is no other wrap-around state.

## Structure
- Shared package `unary_pkg`:
  - `LFSR8_TAPS` constant.
  - `lfsr8_next()` function.
  - `clog2`-based `idx_w_t` width helper.
  - Both SEED-substitution rule and tap constant are reused by the other RNG-based kernels.
- Sub-module `lfsr8`:
  - Ports: clk, rst_n, `seed` parameter, 8-bit `state` output.
  - Instantiated once.
- The shuffle buffer, index mux and multiply gate stay inline in `bisquare_shuffle_u`.

## Test plan
1. **Reset state.** DEPTH=4, SEED=8'h01, bipolar, `rst_n` released.
   - Cycle 0: idx=1, `buf[1]`=1.
   - `in`=1 → `out`=1; `in`=0 → `out`=0.
2. **Saturating input.** Bipolar, `in` held 1 for 64 cycles.
   - Once every index has been visited (by cycle 16), `out`=1 every cycle.
   - `in` held 0 for 64 cycles → `out`=1 after the buffer fills with 0 ((−1)²=1).
3. **Bipolar accuracy.** Bipolar, DEPTH=8, Bernoulli `in` with P(1)=0.75 (value 0.5), 4096 cycles after warm-up.
   - `out` density 0.625±0.03 (value 0.25).
4. **Unipolar accuracy.** BIPOLAR=0, DEPTH=4, Bernoulli P(1)=0.5, 4096 cycles.
   - `out` density 0.25±0.03.
5. **Async reset mid-stream.** `rst_n` pulsed low between clock edges after 100 cycles.
   - `lf`=SEED and buffer = alternating pattern before the next edge.
   - The post-reset output sequence matches scenario 1 bit-for-bit.
6. **LFSR checks.** With SEED=8'h00, the sequence equals the SEED=8'h01 sequence. Seeded 8'h2D, the state returns to 8'h2D after exactly 255 cycles.
